// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int PORT_CPU = 0;
  localparam int PORT_IO  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle between the two requesters (CPU LSU, IO/DMA) and the arbiter.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );
endinterface

// File: rtl/data_mem_bank.sv
// Register-based storage: one cleared-on-reset register per word, guarded write port,
// combinational read mux that returns 0 for addresses beyond NUM_WORDS.
module data_mem_bank #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              oor_o
);

  localparam logic [ADDR_W:0] NUM_WORDS_A = NUM_WORDS[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  assign oor_o = ({1'b0, addr_i} >= NUM_WORDS_A);

  // Each word decodes its own address, so out-of-range writes match no word.
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        mem_q[i] <= '0;
      end else if (we_i && (addr_i == ADDR_W'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (addr_i == ADDR_W'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: IDLE/GNT/RESP FSM, round-robin by default;
// define DATA_MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  data_mem_arbiter_if.slave bus
);

  localparam logic SEL_IO = 1'(PORT_IO);

  state_e            state_q;
  logic              sel_q;
  logic              gnt0_q, gnt1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req_d;
  logic              win_idle_d;
  logic              win_resp_d;
  logic              acc_we_d;
  logic [ADDR_W-1:0] acc_addr_d;
  logic [DATA_W-1:0] acc_wdata_d;
  logic              bank_we_d;
  logic              bank_oor;
  logic [DATA_W-1:0] bank_rdata;

  assign any_req_d = bus.req0 | bus.req1;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  assign win_idle_d = ~bus.req0;
  assign win_resp_d = ~bus.req0;
`else
  logic rr_ptr_q;

  function automatic logic pick(input logic r0, input logic r1, input logic ptr);
    if (r0 && r1) return ptr;
    return r1 & ~r0;
  endfunction

  // In RESP the pointer is about to move to the other port, so arbitrate with that value.
  assign win_idle_d = pick(bus.req0, bus.req1, rr_ptr_q);
  assign win_resp_d = pick(bus.req0, bus.req1, ~sel_q);
`endif

  assign acc_we_d    = (sel_q == SEL_IO) ? bus.we1    : bus.we0;
  assign acc_addr_d  = (sel_q == SEL_IO) ? bus.addr1  : bus.addr0;
  assign acc_wdata_d = (sel_q == SEL_IO) ? bus.wdata1 : bus.wdata0;
  assign bank_we_d   = (state_q == GNT) && acc_we_d;

  data_mem_bank #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_bank (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .we_i    (bank_we_d),
    .addr_i  (acc_addr_d),
    .wdata_i (acc_wdata_d),
    .rdata_o (bank_rdata),
    .oor_o   (bank_oor)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            sel_q   <= win_idle_d;
            gnt0_q  <= (win_idle_d != SEL_IO);
            gnt1_q  <= (win_idle_d == SEL_IO);
            state_q <= GNT;
          end
        end
        GNT: begin
          rdata_q   <= acc_we_d ? '0 : bank_rdata;
          err_q     <= bank_oor;
          rvalid0_q <= (sel_q != SEL_IO);
          rvalid1_q <= (sel_q == SEL_IO);
          state_q   <= RESP;
        end
        RESP: begin
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
          rr_ptr_q <= ~sel_q;
`endif
          if (any_req_d) begin
            sel_q   <= win_resp_d;
            gnt0_q  <= (win_resp_d != SEL_IO);
            gnt1_q  <= (win_resp_d == SEL_IO);
            state_q <= GNT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter (NUM_WORDS=12); expected grants/responses are queued
// by the stimulus thread and checked by an independent monitor.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  data_mem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  data_mem_arbiter #(
    .DATA_W    (8),
    .NUM_WORDS (12),
    .ADDR_W    (4)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic gnt_of(input int p);
    return (p == PORT_IO) ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == PORT_IO) ? 2'b10 : 2'b01;
  endfunction

  // Monitor
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (bus.gnt0 || bus.gnt1) begin
        if (exp_gnt.size() == 0) fail_now("gnt_unexpected");
        else check("gnt_port", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, onehot(exp_gnt.pop_front())});
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_rsp.size() == 0) begin
          fail_now("rvalid_unexpected");
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, {30'd0, onehot(r.port)});
          check("rdata", {24'd0, bus.rdata}, {24'd0, r.rdata});
          check("err", {31'd0, bus.err}, {31'd0, r.err});
        end
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [3:0] a, input logic [7:0] d);
    if (p == PORT_IO) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == PORT_IO) bus.req1 = 1'b0;
    else bus.req0 = 1'b0;
  endtask

  // One access: hold req until gnt, release it in the following (RESP) cycle.
  task automatic access(input int p, input logic we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err);
    bit got = 0;
    exp_gnt.push_back(p);
    exp_rsp.push_back('{p, exp_rd, exp_err});
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge Clk); #1;
      if (gnt_of(p)) got = 1;
    end
    if (!got) fail_now("gnt_timeout");
    @(posedge Clk); #1;
    drop(p);
  endtask

  // Read with req held continuously across n grants.
  task automatic hold_port(input int p, input logic [3:0] a, input int n, input int gap);
    int got = 0;
    int last = 0;
    drive(p, 1'b1, 1'b0, a, 8'h00);
    for (int i = 0; i < 40 && got < n; i++) begin
      @(posedge Clk); #1;
      if (gnt_of(p)) begin
        if (got > 0) check("gnt_gap", 32'(cyc - last), 32'(gap));
        last = cyc;
        got++;
      end
    end
    if (got < n) fail_now("hold_gnt_timeout");
    @(posedge Clk); #1;
    drop(p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    bit got;
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    Reset_n = 1'b1;
    idle(1);

    // Port 0 write then read back
    access(0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0);
    access(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);
    idle(3);

    // Contention: fresh reset so rr_ptr=0, seed words 1/2 from port 1 (pointer ends on 0)
    pulse_reset();
    access(1, 1'b1, 4'd1, 8'h11, 8'h00, 1'b0);
    access(1, 1'b1, 4'd2, 8'h22, 8'h00, 1'b0);
    idle(3);
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(1);
    exp_rsp.push_back('{0, 8'h11, 1'b0}); exp_rsp.push_back('{0, 8'h11, 1'b0});
    exp_rsp.push_back('{1, 8'h22, 1'b0}); exp_rsp.push_back('{1, 8'h22, 1'b0});
    fork
      hold_port(0, 4'd1, 2, 2);
      hold_port(1, 4'd2, 2, 2);
    join
`else
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_rsp.push_back('{0, 8'h11, 1'b0}); exp_rsp.push_back('{1, 8'h22, 1'b0});
    exp_rsp.push_back('{0, 8'h11, 1'b0}); exp_rsp.push_back('{1, 8'h22, 1'b0});
    fork
      hold_port(0, 4'd1, 2, 4);
      hold_port(1, 4'd2, 2, 4);
    join
`endif
    idle(3);

    // Cross-port read-after-write
    access(1, 1'b1, 4'd5, 8'h3C, 8'h00, 1'b0);
    access(0, 1'b0, 4'd5, 8'h00, 8'h3C, 1'b0);
    idle(2);

    // Out-of-range with NUM_WORDS=12
    access(0, 1'b1, 4'd11, 8'h5A, 8'h00, 1'b0);
    access(0, 1'b1, 4'd13, 8'hFF, 8'h00, 1'b1);
    access(0, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1);
    access(0, 1'b1, 4'd12, 8'hEE, 8'h00, 1'b1);
    access(0, 1'b0, 4'd12, 8'h00, 8'h00, 1'b1);
    access(0, 1'b0, 4'd11, 8'h00, 8'h5A, 1'b0);
    idle(3);

    // Reset during GNT of a write: aborted, no rvalid
    drive(0, 1'b1, 1'b1, 4'd2, 8'h77);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge Clk); #1;
      if (bus.gnt0) got = 1;
    end
    if (!got) fail_now("abort_gnt_timeout");
    Reset_n = 1'b0;
    drop(0);
    @(posedge Clk); #1;
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("abort_rvalid_late", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    access(0, 1'b0, 4'd2, 8'h00, 8'h00, 1'b0);
    idle(3);

    // Quiet bus
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check("idle_outs", {28'd0, bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0}, 32'd0);
      check("idle_state", 32'(dut.state_q), 32'(IDLE));
    end

    for (int i = 0; i < 20 && (exp_gnt.size() != 0 || exp_rsp.size() != 0); i++) idle(1);
    check("gnt_queue_left", 32'(exp_gnt.size()), 32'd0);
    check("rsp_queue_left", 32'(exp_rsp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
